// File: rtl/encoder_mmio_pkg.sv
// Shared definitions for the encoder register block: word addresses,
// CTRL field positions and DELTA saturation limits.
package encoder_mmio_pkg;

  localparam logic [1:0] ADDR_VALUE  = 2'd0;
  localparam logic [1:0] ADDR_DELTA  = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_TSTAMP = 2'd3;

  localparam int CTRL_IRQ_EN_BIT  = 0;
  localparam int CTRL_PENDING_BIT = 1;
  localparam int CTRL_THR_LSB     = 8;
  localparam int CTRL_THR_MSB     = 15;

  localparam logic [15:0] DELTA_MAX = 16'h7FFF;
  localparam logic [15:0] DELTA_MIN = 16'h8000;
  localparam logic [14:0] MAG_MAX   = 15'h7FFF;

  // CTRL register as seen on a read
  typedef struct packed {
    logic [7:0] threshold;
    logic [5:0] rsvd;
    logic       pending;
    logic       irq_en;
  } ctrl_t;

endpackage

// File: rtl/encoder_mmio_delta_sat.sv
// Saturating signed difference a-b. The 17-bit difference is clamped to the
// 16-bit signed range; mag is |res| with the most negative value folded to
// the largest positive magnitude so it fits in 15 bits.
module delta_sat
  import encoder_mmio_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] res,
  output logic [14:0] mag
);

  logic [16:0] diff;

  assign diff = {a[15], a} - {b[15], b};

  // Overflow shows up as the two top bits of the 17-bit difference disagreeing
  always_comb begin
    res = diff[15:0];
    if (diff[16] != diff[15]) begin
      res = diff[16] ? DELTA_MIN : DELTA_MAX;
    end
  end

  // Magnitude of the clamped result
  always_comb begin
    mag = res[14:0];
    if (res[15]) begin
      if (res == DELTA_MIN) begin
        mag = MAG_MAX;
      end else begin
        mag = (~res[14:0]) + 15'd1;
      end
    end
  end

endmodule

// File: rtl/encoder_mmio.sv
// CPU register block in front of one rotary encoder: live value and preset,
// saturating delta-since-last-read, change-threshold pending flag and level
// IRQ. Optional timestamp capture on encoder change is built in when
// ENCODER_MMIO_TIMESTAMP_EN is defined; otherwise address 3 reads zero.
module encoder_mmio
  import encoder_mmio_pkg::*;
#(
  parameter int THRESH_RESET = 1,
  parameter int TS_WIDTH     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic [1:0]  we,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        ready,
  input  logic [15:0] enc_q,
  output logic [1:0]  enc_we,
  output logic [15:0] enc_din,
  output logic        irq
);

  logic [15:0] snapshot;
  logic        pending;
  logic        irq_en;
  logic [7:0]  threshold;
  logic        resync;

  logic [15:0] delta;
  logic [14:0] delta_mag;
  logic [7:0]  thr_eff;
  logic [15:0] ts_rd;
  logic [15:0] rdata;
  ctrl_t       ctrl_rd;

  logic rd_acc, wr_acc, value_wr, delta_rd, ctrl_wr, w1c, set_cond;

  delta_sat u_delta_sat (
    .a   (enc_q),
    .b   (snapshot),
    .res (delta),
    .mag (delta_mag)
  );

  assign rd_acc   = sel & (we == 2'b00);
  assign wr_acc   = sel & (we != 2'b00);
  assign value_wr = wr_acc & (addr == ADDR_VALUE);
  assign delta_rd = rd_acc & (addr == ADDR_DELTA);
  assign ctrl_wr  = wr_acc & (addr == ADDR_CTRL);
  assign w1c      = ctrl_wr & we[0] & din[CTRL_PENDING_BIT];

  // A zero threshold behaves as one so a still encoder never raises pending
  assign thr_eff  = (threshold == 8'd0) ? 8'd1 : threshold;
  // No set while a preset is landing: the snapshot is stale until resync completes
  assign set_cond = ~resync & ~value_wr & (delta_mag >= {7'd0, thr_eff});

  // Preset port passes straight through so the encoder captures it this cycle
  always_comb begin
    enc_we  = value_wr ? we : 2'b00;
    enc_din = din;
  end

`ifdef ENCODER_MMIO_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt;
  logic [TS_WIDTH-1:0] ts_latch;
  logic [15:0]         enc_prev;
  logic                enc_chg;

  // Free-running counter; latch it one cycle after the registered change detect
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_cnt   <= '0;
      ts_latch <= '0;
      enc_prev <= '0;
      enc_chg  <= 1'b0;
    end else begin
      ts_cnt   <= ts_cnt + TS_WIDTH'(1);
      enc_prev <= enc_q;
      enc_chg  <= (enc_q != enc_prev);
      if (enc_chg) begin
        ts_latch <= ts_cnt;
      end
    end
  end

  assign ts_rd = 16'(ts_latch);
`else
  logic [TS_WIDTH-1:0] ts_zero;

  assign ts_zero = '0;
  assign ts_rd   = 16'(ts_zero);
`endif

  // Read mux
  always_comb begin
    ctrl_rd           = '0;
    ctrl_rd.threshold = threshold;
    ctrl_rd.pending   = pending;
    ctrl_rd.irq_en    = irq_en;
    rdata             = '0;
    case (addr)
      ADDR_VALUE:  rdata = enc_q;
      ADDR_DELTA:  rdata = delta;
      ADDR_CTRL:   rdata = ctrl_rd;
      ADDR_TSTAMP: rdata = ts_rd;
      default:     rdata = '0;
    endcase
  end

  // Bus response: ready follows sel by one cycle, dout loads only on reads
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready <= 1'b0;
      dout  <= '0;
    end else begin
      ready <= sel;
      if (rd_acc) begin
        dout <= rdata;
      end
    end
  end

  // CTRL writable fields, byte enables honoured
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_en    <= 1'b0;
      threshold <= 8'(THRESH_RESET);
    end else if (ctrl_wr) begin
      if (we[0]) begin
        irq_en <= din[CTRL_IRQ_EN_BIT];
      end
      if (we[1]) begin
        threshold <= din[CTRL_THR_MSB:CTRL_THR_LSB];
      end
    end
  end

  // Pending: DELTA read clears and wins, then a threshold hit, then W1C
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else if (delta_rd) begin
      pending <= 1'b0;
    end else if (set_cond) begin
      pending <= 1'b1;
    end else if (w1c) begin
      pending <= 1'b0;
    end
  end

  // Snapshot follows enc_q on a DELTA read and the cycle after a preset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snapshot <= '0;
      resync   <= 1'b0;
    end else begin
      resync <= value_wr;
      if (delta_rd || resync) begin
        snapshot <= enc_q;
      end
    end
  end

  // Registered level interrupt
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_en & pending;
    end
  end

endmodule
